// File: rtl/long_mul_writer.sv
// Multicycle 32x32->64 long multiplier (UMULL/SMULL/UMLAL/SMLAL) driving the register file's
// paired write port. Shift-add over WIDTH cycles on unsigned magnitudes, sign and accumulate applied at the end.
module long_mul_writer #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_signed,
    input  logic              accumulate,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [WIDTH-1:0]  acc_lo,
    input  logic [WIDTH-1:0]  acc_hi,
    input  logic [ADDR_W-1:0] rd_lo,
    input  logic [ADDR_W-1:0] rd_hi,
    input  logic              flush,
    output logic              busy,
    output logic              we,
    output logic [ADDR_W-1:0] wa_lo,
    output logic [ADDR_W-1:0] wa_hi,
    output logic [WIDTH-1:0]  wd_lo,
    output logic [WIDTH-1:0]  wd_hi,
    output logic              flag_n,
    output logic              flag_z
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [ADDR_W-1:0] PC_ADDR = '1;

    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;
    state_t state, state_nx;

    logic [2*WIDTH-1:0] prod, mcand, acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               sign, pc_hit;
    logic [ADDR_W-1:0]  rlo, rhi;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] step_sum, signed_sum, result;
    logic               launch, finish;

    // A WIDTH-bit unsigned magnitude already holds |-2^(WIDTH-1)|, so no extra bit is needed.
    assign mag_a      = (is_signed && op_a[WIDTH-1]) ? ('0 - op_a) : op_a;
    assign mag_b      = (is_signed && op_b[WIDTH-1]) ? ('0 - op_b) : op_b;
    assign step_sum   = prod + (mplier[0] ? mcand : '0);
    assign signed_sum = sign ? ('0 - step_sum) : step_sum;
    assign result     = signed_sum + acc;

    assign launch = (state == IDLE) && start && !flush;
    assign finish = (state == CALC) && !flush && (count == '0);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = CALC;
            CALC:    if (flush) state_nx = IDLE;
                     else if (count == '0) state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            sign   <= 1'b0;
            pc_hit <= 1'b0;
            rlo    <= '0;
            rhi    <= '0;
        end else if (launch) begin
            prod   <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= accumulate ? {acc_hi, acc_lo} : '0;
            count  <= CW'(WIDTH - 1);
            sign   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            pc_hit <= (rd_lo == PC_ADDR) || (rd_hi == PC_ADDR);
            rlo    <= rd_lo;
            rhi    <= rd_hi;
        end else if (state == CALC) begin
            prod   <= step_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 1'b1;
        end
    end

    // Write-port outputs are registered and live only during the single WRITE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we     <= 1'b0;
            wa_lo  <= '0;
            wa_hi  <= '0;
            wd_lo  <= '0;
            wd_hi  <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
        end else if (finish) begin
            we     <= !pc_hit;
            wa_lo  <= rlo;
            wa_hi  <= rhi;
            wd_lo  <= result[WIDTH-1:0];
            wd_hi  <= result[2*WIDTH-1:WIDTH];
            flag_n <= result[2*WIDTH-1];
            flag_z <= (result == '0);
        end else begin
            we     <= 1'b0;
            wa_lo  <= '0;
            wa_hi  <= '0;
            wd_lo  <= '0;
            wd_hi  <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
        end
    end
endmodule

// File: tb/tb_long_mul_writer.sv
// Directed bench for long_mul_writer: result values, write timing, flush, busy-start, reset and R15 cases.
module tb_long_mul_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_signed, accumulate, flush;
    logic [31:0] op_a, op_b, acc_lo, acc_hi;
    logic [3:0]  rd_lo, rd_hi;
    logic        busy, we, flag_n, flag_z;
    logic [3:0]  wa_lo, wa_hi;
    logic [31:0] wd_lo, wd_hi;

    int nvec = 0;
    int nerr = 0;

    long_mul_writer #(.WIDTH(32), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .accumulate(accumulate), .op_a(op_a), .op_b(op_b), .acc_lo(acc_lo),
        .acc_hi(acc_hi), .rd_lo(rd_lo), .rd_hi(rd_hi), .flush(flush),
        .busy(busy), .we(we), .wa_lo(wa_lo), .wa_hi(wa_hi), .wd_lo(wd_lo),
        .wd_hi(wd_hi), .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start in the current cycle; returns in cycle 1 of the operation.
    task automatic launch(input logic sg, input logic ac, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] alo, input logic [31:0] ahi,
                          input logic [3:0] rl, input logic [3:0] rh);
        is_signed = sg; accumulate = ac; op_a = a; op_b = b;
        acc_lo = alo; acc_hi = ahi; rd_lo = rl; rd_hi = rh;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Samples the current cycle then advances, n times; counts cycles seen with we / busy high.
    task automatic run_cycles(input int n, output int we_seen, output int busy_seen);
        we_seen = 0; busy_seen = 0;
        repeat (n) begin
            if (we)   we_seen++;
            if (busy) busy_seen++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 0; flush = 0; is_signed = 0; accumulate = 0;
        op_a = 0; op_b = 0; acc_lo = 0; acc_hi = 0; rd_lo = 0; rd_hi = 0;
        tick(); tick();
        nvec++;
        if ({busy, we, wa_lo, wa_hi, wd_lo, wd_hi, flag_n, flag_z} !== '0) begin
            nerr++; $display("FAIL reset_outputs: got busy=%b we=%b wd=%h_%h want all zero", busy, we, wd_hi, wd_lo);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_umull();
        int w, b;
        launch(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 4'd2, 4'd3);
        run_cycles(32, w, b);
        nvec++;
        if (w !== 0 || b !== 32) begin
            nerr++; $display("FAIL umull_timing: got we_cycles=%0d busy_cycles=%0d want 0 and 32", w, b);
        end
        nvec++;
        if ({we, wa_lo, wa_hi, wd_hi, wd_lo, flag_n, flag_z} !== {1'b1, 4'd2, 4'd3, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0}) begin
            nerr++; $display("FAIL umull_ffxff: got we=%b wa=%0d/%0d wd=%h_%h n=%b z=%b want 1 2/3 fffffffe_00000001 1 0",
                             we, wa_lo, wa_hi, wd_hi, wd_lo, flag_n, flag_z);
        end
        tick();
        nvec++;
        if ({we, busy, wd_lo, wd_hi} !== '0) begin
            nerr++; $display("FAIL umull_after_write: got we=%b busy=%b wd=%h_%h want zeros", we, busy, wd_hi, wd_lo);
        end
        launch(0, 0, 32'h12345678, 32'h10, 0, 0, 4'd5, 4'd5);
        run_cycles(32, w, b);
        nvec++;
        if ({we, wa_lo, wa_hi, wd_hi, wd_lo, flag_n} !== {1'b1, 4'd5, 4'd5, 32'h00000001, 32'h23456780, 1'b0}) begin
            nerr++; $display("FAIL umull_same_rd: got we=%b wa=%0d/%0d wd=%h_%h n=%b want 1 5/5 00000001_23456780 0",
                             we, wa_lo, wa_hi, wd_hi, wd_lo, flag_n);
        end
        tick();
    endtask

    task automatic test_smull();
        int w, b;
        launch(1, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 4'd1, 4'd2);
        run_cycles(32, w, b);
        nvec++;
        if ({we, wd_hi, wd_lo, flag_n, flag_z} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0}) begin
            nerr++; $display("FAIL smull_m1x1: got we=%b wd=%h_%h n=%b z=%b want 1 ffffffff_ffffffff 1 0", we, wd_hi, wd_lo, flag_n, flag_z);
        end
        tick();
        launch(1, 0, 32'h80000000, 32'h80000000, 0, 0, 4'd1, 4'd2);
        run_cycles(32, w, b);
        nvec++;
        if ({we, wd_hi, wd_lo, flag_n} !== {1'b1, 32'h40000000, 32'h0, 1'b0}) begin
            nerr++; $display("FAIL smull_minxmin: got we=%b wd=%h_%h n=%b want 1 40000000_00000000 0", we, wd_hi, wd_lo, flag_n);
        end
        tick();
    endtask

    task automatic test_mlal();
        int w, b;
        launch(0, 1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, 4'd7);
        run_cycles(32, w, b);
        nvec++;
        if ({wd_hi, wd_lo, flag_n, flag_z} !== {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0}) begin
            nerr++; $display("FAIL umlal_acc_only: got wd=%h_%h n=%b z=%b want ffffffff_ffffffff 1 0", wd_hi, wd_lo, flag_n, flag_z);
        end
        tick();
        launch(0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 4'd6, 4'd7);
        run_cycles(32, w, b);
        nvec++;
        if ({we, wd_hi, wd_lo, flag_n, flag_z} !== {1'b1, 64'h0, 1'b0, 1'b1}) begin
            nerr++; $display("FAIL umlal_zero: got we=%b wd=%h_%h n=%b z=%b want 1 0_0 0 1", we, wd_hi, wd_lo, flag_n, flag_z);
        end
        tick();
        launch(0, 1, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, 4'd7);
        run_cycles(32, w, b);
        nvec++;
        if ({wd_hi, wd_lo, flag_z} !== {64'h0, 1'b1}) begin
            nerr++; $display("FAIL umlal_wrap: got wd=%h_%h z=%b want 0_0 1", wd_hi, wd_lo, flag_z);
        end
        tick();
        launch(1, 1, 32'hFFFFFFFE, 32'h3, 32'd10, 32'h0, 4'd6, 4'd7);
        run_cycles(32, w, b);
        nvec++;
        if ({wd_hi, wd_lo, flag_n} !== {32'h0, 32'h4, 1'b0}) begin
            nerr++; $display("FAIL smlal_m2x3p10: got wd=%h_%h n=%b want 00000000_00000004 0", wd_hi, wd_lo, flag_n);
        end
        tick();
    endtask

    task automatic test_flush();
        int w, b;
        launch(0, 0, 32'd9, 32'd9, 0, 0, 4'd1, 4'd2);
        run_cycles(9, w, b);
        flush = 1'b1;
        nvec++;
        if (busy !== 1'b1 || w !== 0) begin
            nerr++; $display("FAIL flush_cycle10: got busy=%b we_cycles=%0d want 1 and 0", busy, w);
        end
        tick();
        flush = 1'b0;
        nvec++;
        if (busy !== 1'b0 || we !== 1'b0) begin
            nerr++; $display("FAIL flush_cycle11: got busy=%b we=%b want 0 0", busy, we);
        end
        tick();
        launch(0, 0, 32'd9, 32'd9, 0, 0, 4'd1, 4'd2);
        run_cycles(32, w, b);
        nvec++;
        if (w !== 0 || we !== 1'b1 || wd_lo !== 32'd81 || wd_hi !== 32'd0) begin
            nerr++; $display("FAIL flush_restart: got early_we=%0d we=%b wd=%h_%h want 0 1 00000000_00000051", w, we, wd_hi, wd_lo);
        end
        tick();
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        nvec++;
        if (busy !== 1'b0) begin
            nerr++; $display("FAIL flush_beats_start: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int w, b;
        launch(0, 0, 32'd7, 32'd6, 0, 0, 4'd4, 4'd5);
        run_cycles(4, w, b);
        start = 1'b1; op_a = 32'd100;
        tick();
        start = 1'b0;
        run_cycles(27, w, b);
        nvec++;
        if (w !== 0 || we !== 1'b1 || wd_lo !== 32'd42 || wd_hi !== 32'd0) begin
            nerr++; $display("FAIL busy_start_ignored: got early_we=%0d we=%b wd=%h_%h want 0 1 00000000_0000002a", w, we, wd_hi, wd_lo);
        end
        run_cycles(10, w, b);
        nvec++;
        if (w !== 1 || b !== 1 || busy !== 1'b0) begin
            nerr++; $display("FAIL busy_start_single_pulse: got we_cycles=%0d busy_cycles=%0d busy=%b want 1 1 0", w, b, busy);
        end
    endtask

    task automatic test_async_reset();
        int w, b;
        launch(0, 0, 32'd3, 32'd5, 0, 0, 4'd1, 4'd2);
        run_cycles(19, w, b);
        reset = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b0 || we !== 1'b0 || wd_lo !== 32'd0) begin
            nerr++; $display("FAIL reset_mid_calc: got busy=%b we=%b wd_lo=%h want 0 0 0", busy, we, wd_lo);
        end
        tick();
        reset = 1'b1;
        launch(0, 0, 32'd3, 32'd5, 0, 0, 4'd1, 4'd2);
        run_cycles(32, w, b);
        nvec++;
        if (we !== 1'b1 || wd_lo !== 32'd15) begin
            nerr++; $display("FAIL reset_pre_write: got we=%b wd_lo=%h want 1 0000000f", we, wd_lo);
        end
        reset = 1'b0;
        #1;
        nvec++;
        if (we !== 1'b0 || wd_lo !== 32'd0 || busy !== 1'b0 || flag_n !== 1'b0) begin
            nerr++; $display("FAIL reset_mid_write: got we=%b wd_lo=%h busy=%b want 0 0 0", we, wd_lo, busy);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pc_dest();
        int w, b;
        launch(0, 0, 32'd0, 32'd5, 0, 0, 4'd2, 4'd15);
        run_cycles(32, w, b);
        nvec++;
        if (we !== 1'b0 || flag_z !== 1'b1 || busy !== 1'b1) begin
            nerr++; $display("FAIL r15_write_cycle: got we=%b z=%b busy=%b want 0 1 1", we, flag_z, busy);
        end
        begin
            int w2, b2;
            run_cycles(8, w2, b2);
            nvec++;
            if (w + w2 !== 0 || b + b2 !== 33) begin
                nerr++; $display("FAIL r15_busy_span: got we_cycles=%0d busy_cycles=%0d want 0 and 33", w + w2, b + b2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_umull();
        test_smull();
        test_mlal();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_pc_dest();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
